// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits answer combinationally; misses and all stores stall until main memory completes.
//
//   state | meaning
//   IDLE  | accepting CPU requests; read hits served from the arrays
//   FILL  | read miss outstanding; line installed when memory returns data
//   WRITE | store outstanding; cached copy updated on completion if it was a hit
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_array  [SETS];
  logic [DATA_WIDTH-1:0] data_array [SETS];

  logic [IDX-1:0]        index;
  logic [TAG_W-1:0]      tag;
  logic                  hit;

  logic [IDX-1:0]        lat_index;
  logic [TAG_W-1:0]      lat_tag;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_hit;

  logic                  rd_hit;
  logic                  rd_miss;
  logic                  wr_accept;
  logic                  fill_done;
  logic                  write_done;

  assign index = cpu_addr[2 +: IDX];
  assign tag   = cpu_addr[ADDR_WIDTH-1:2+IDX];
  assign hit   = valid[index] && (tag_array[index] == tag);

  assign rd_hit     = (state == IDLE) && cpu_req && !cpu_we && hit;
  assign rd_miss    = (state == IDLE) && cpu_req && !cpu_we && !hit;
  assign wr_accept  = (state == IDLE) && cpu_req && cpu_we;
  assign fill_done  = (state == FILL) && mem_ready;
  assign write_done = (state == WRITE) && mem_ready;

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    case (state)
      IDLE: begin
        cpu_stall = cpu_req && (cpu_we || !hit);
        if (rd_hit) begin
          cpu_rdata = data_array[index];
        end
        if (rd_miss) begin
          state_nxt = FILL;
        end else if (wr_accept) begin
          state_nxt = WRITE;
        end
      end
      FILL: begin
        cpu_stall = !mem_ready;
        if (mem_ready) begin
          cpu_rdata = mem_rdata;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        cpu_stall = !mem_ready;
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_done) begin
      valid[lat_index] <= 1'b1;
    end
  end

  // Memory-side outputs are registered and held stable for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (rd_miss) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
    end else if (wr_accept) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata <= cpu_wdata;
    end else if (fill_done || write_done) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rd_hit) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if (rd_miss) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

  // Tag/data storage and the latched request carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (rd_miss || wr_accept) begin
      lat_index <= index;
      lat_tag   <= tag;
      lat_wdata <= cpu_wdata;
      lat_hit   <= hit;
    end
    if (fill_done) begin
      tag_array[lat_index]  <= lat_tag;
      data_array[lat_index] <= mem_rdata;
    end
    if (write_done && lat_hit) begin
      data_array[lat_index] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: the bench plays main memory and predicts hits from
// a line-address map per set, with expected data taken from a word-level memory image.
module tb_data_cache;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [bit [29:0]];
  bit          m_valid [16];
  bit [29:0]   m_line  [16];
  logic [15:0] m_hits;
  logic [15:0] m_misses;

  data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check_counters();
    check("hit_cnt", {16'd0, hit_cnt}, {16'd0, m_hits});
    check("miss_cnt", {16'd0, miss_cnt}, {16'd0, m_misses});
  endtask

  // One complete CPU access; lat = cycles from mem_req rising to mem_ready.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    bit [29:0] waddr;
    int        idx;
    bit        hit;
    waddr = addr[31:2];
    idx   = int'(waddr[3:0]);
    hit   = m_valid[idx] && (m_line[idx] == waddr);
    if (!mem_model.exists(waddr)) mem_model[waddr] = $urandom;

    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    if (!we && hit) begin
      check("hit_stall", {31'd0, cpu_stall}, 32'd0);
      check("hit_rdata", cpu_rdata, mem_model[waddr]);
      check("hit_no_memreq", {31'd0, mem_req}, 32'd0);
      m_hits++;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      check_counters();
      return;
    end
    check("accept_stall", {31'd0, cpu_stall}, 32'd1);
    if (!we) m_misses++;
    @(posedge clk); #1;
    if ($urandom_range(0, 1) == 1) begin
      cpu_req = 1'b0;
      cpu_we = ~we;
      cpu_addr = $urandom;
    end
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("wait_stall", {31'd0, cpu_stall}, 32'd1);
      check("wait_mem_req", {31'd0, mem_req}, 32'd1);
      check("wait_mem_we", {31'd0, mem_we}, {31'd0, we});
      check("wait_mem_addr", mem_addr, {waddr, 2'b00});
      if (we) check("wait_mem_wdata", mem_wdata, wdata);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    mem_rdata = we ? $urandom : mem_model[waddr];
    @(negedge clk);
    check("done_stall", {31'd0, cpu_stall}, 32'd0);
    check("done_mem_req", {31'd0, mem_req}, 32'd1);
    check("done_mem_addr", mem_addr, {waddr, 2'b00});
    check("done_rdata", cpu_rdata, we ? 32'd0 : mem_model[waddr]);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    if (we) begin
      mem_model[waddr] = wdata;
    end else begin
      m_valid[idx] = 1'b1;
      m_line[idx]  = waddr;
    end
    check("after_mem_req", {31'd0, mem_req}, 32'd0);
    check_counters();
  endtask

  task automatic idle_ready_glitch();
    @(posedge clk); #1;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    check("idle_stall", {31'd0, cpu_stall}, 32'd0);
    check("idle_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("idle_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    model_clear();
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check_counters();
    do_reset();

    // Miss, then hit, on a known word.
    mem_model[30'h10] = 32'hDEAD_BEEF;
    access(1'b0, 32'h40, 32'd0, 3);
    access(1'b0, 32'h40, 32'd0, 1);
    // Store to a cached line then read back.
    access(1'b1, 32'h40, 32'h1234_5678, 2);
    access(1'b0, 32'h40, 32'd0, 1);
    // Store to an uncached line does not allocate.
    access(1'b1, 32'h80, 32'hCAFE_F00D, 2);
    access(1'b0, 32'h80, 32'd0, 2);
    // Same-set conflict.
    access(1'b0, 32'h000, 32'd0, 2);
    access(1'b0, 32'h040, 32'd0, 1);
    access(1'b0, 32'h000, 32'd0, 4);
    idle_ready_glitch();

    // Reset while a fill is outstanding.
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    @(posedge clk); #1;
    check("fill_mem_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_rdata", cpu_rdata, 32'd0);
    check("midrst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    check("midrst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    access(1'b0, 32'h100, 32'd0, 2);

    for (int n = 0; n < 400; n++) begin
      access($urandom_range(0, 9) < 3, rand_addr(), $urandom, $urandom_range(1, 5));
      if ($urandom_range(0, 15) == 0) idle_ready_glitch();
    end

    // Byte offset ignored, then hit counter wrap.
    do_reset();
    access(1'b0, 32'h43, 32'd0, 2);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    repeat (65535) @(posedge clk);
    #1;
    check("hit_cnt_ffff", {16'd0, hit_cnt}, 32'h0000_FFFF);
    @(posedge clk); #1;
    check("hit_cnt_wrap", {16'd0, hit_cnt}, 32'd0);
    check("wrap_miss_cnt", {16'd0, miss_cnt}, 32'd1);
    cpu_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
